// File: rtl/game_tick_sched_pkg.sv
// ----------------------------------------------------------------------------
// game_tick_sched_pkg
// Shared game constants and types for the tick scheduler, the HUD and the
// test bench.
//   TICK_BASE_DIV_DEFAULT : clk cycles per 8 Hz base tick on the board clock
//   BOOST_TICKS_DEFAULT   : "Faster" reward window length in base ticks (10 s)
//   DIV_CNT_W             : width of the base-tick divider counter
//   boost_state_e         : player-rate FSM states (ST_NORMAL, ST_BOOST)
// ----------------------------------------------------------------------------
package game_tick_sched_pkg;

   localparam int unsigned TICK_BASE_DIV_DEFAULT = 32'd6250000;
   localparam int unsigned BOOST_TICKS_DEFAULT   = 32'd80;
   localparam int unsigned DIV_CNT_W             = 32'd24;

   typedef enum logic [0:0] {
      ST_NORMAL = 1'b0,
      ST_BOOST  = 1'b1
   } boost_state_e;

endpackage : game_tick_sched_pkg

// File: rtl/game_tick_sched_tick_div.sv
// ----------------------------------------------------------------------------
// tick_div
// Enable-gated wrap counter that produces the 8 Hz base tick.
// Ports:
//   clk         : board clock
//   rst_n       : asynchronous active-low reset
//   i_en        : count enable; the counter holds while low
//   o_base_tick : high for the one edge on which the counter wraps
// ----------------------------------------------------------------------------
module tick_div
   import game_tick_sched_pkg::*;
#(
   parameter int unsigned BASE_DIV = TICK_BASE_DIV_DEFAULT
)
(
   input  logic clk,
   input  logic rst_n,
   input  logic i_en,
   output logic o_base_tick
);

   localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(BASE_DIV - 32'd1);

   logic [DIV_CNT_W-1:0] r_cnt;
   logic                 w_at_last;

   assign w_at_last   = (r_cnt == DIV_LAST);
   // The tick is qualified by the enable so a paused counter sitting on its
   // last value cannot emit a strobe on every paused cycle.
   assign o_base_tick = i_en & w_at_last;

   // Divider counter: counts enabled edges, wraps after BASE_DIV of them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_en) begin
         if (w_at_last) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + DIV_CNT_W'(1);
         end
      end
   end

endmodule : tick_div

// File: rtl/game_tick_sched.sv
// ----------------------------------------------------------------------------
// game_tick_sched
// Game-rate tick scheduler: single-cycle enable strobes at 8/4/2 Hz derived
// from the board clock, plus the "Faster" reward boost window that doubles
// the player rate.
// Ports:
//   clk           : board clock (single domain)
//   rst_n         : asynchronous active-low reset
//   en            : run enable, low = paused
//   reward_faster : pickup pulse, starts/restarts the boost window
//   reward_test   : test level, forces boost_active while high
//   tick_8hz      : bullet-rate strobe (every base tick)
//   tick_4hz      : player-rate strobe (every base tick while boosted)
//   tick_2hz      : enemy-rate strobe
//   boost_active  : boost in effect (registered)
//   boost_remain  : base ticks left in the boost window
// ----------------------------------------------------------------------------
module game_tick_sched
   import game_tick_sched_pkg::*;
#(
   parameter int unsigned BASE_DIV    = TICK_BASE_DIV_DEFAULT,
   parameter int unsigned BOOST_TICKS = BOOST_TICKS_DEFAULT
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       reward_faster,
   input  logic       reward_test,
   output logic       tick_8hz,
   output logic       tick_4hz,
   output logic       tick_2hz,
   output logic       boost_active,
   output logic [7:0] boost_remain
);

   localparam logic [7:0] BOOST_LOAD = 8'(BOOST_TICKS);

   logic         w_base_tick;
   boost_state_e r_state;
   boost_state_e w_state_nxt;
   logic [7:0]   r_remain;
   logic [7:0]   w_remain_nxt;
   logic         w_boost_nxt;
   logic [1:0]   r_phase;
   logic         r_tick_8hz;
   logic         r_tick_4hz;
   logic         r_tick_2hz;
   logic         r_boost_active;

   tick_div #(
      .BASE_DIV    (BASE_DIV)
   ) u_tick_div (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_en        (en),
      .o_base_tick (w_base_tick)
   );

   // Boost FSM next state and remaining-window count.
   always_comb begin
      w_state_nxt  = r_state;
      w_remain_nxt = r_remain;
      case (r_state)
         ST_NORMAL: begin
            if (reward_faster) begin
               w_state_nxt  = ST_BOOST;
               w_remain_nxt = BOOST_LOAD;
            end else begin
               w_state_nxt  = ST_NORMAL;
               w_remain_nxt = r_remain;
            end
         end
         ST_BOOST: begin
            // A pickup reloads the window even on a decrementing edge.
            if (reward_faster) begin
               w_remain_nxt = BOOST_LOAD;
            end else if (w_base_tick) begin
               if (r_remain == 8'd1) begin
                  w_state_nxt  = ST_NORMAL;
                  w_remain_nxt = 8'd0;
               end else begin
                  w_remain_nxt = r_remain - 8'd1;
               end
            end else begin
               w_remain_nxt = r_remain;
            end
         end
         default: begin
            w_state_nxt  = ST_NORMAL;
            w_remain_nxt = 8'd0;
         end
      endcase
      // The test level overrides the visible flag only, never the window.
      w_boost_nxt = (w_state_nxt == ST_BOOST) | reward_test;
   end

   // FSM state, window count and boost flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= ST_NORMAL;
         r_remain       <= 8'd0;
         r_boost_active <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_remain       <= w_remain_nxt;
         r_boost_active <= w_boost_nxt;
      end
   end

   // Phase counter and strobe registers; strobes use pre-update phase/boost,
   // so the tick that ends the window is still a boosted player tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase    <= 2'd0;
         r_tick_8hz <= 1'b0;
         r_tick_4hz <= 1'b0;
         r_tick_2hz <= 1'b0;
      end else begin
         r_tick_8hz <= w_base_tick;
         r_tick_4hz <= w_base_tick & (r_boost_active | r_phase[0]);
         r_tick_2hz <= w_base_tick & (r_phase == 2'd3);
         if (w_base_tick) begin
            r_phase <= r_phase + 2'd1;
         end
      end
   end

   assign tick_8hz     = r_tick_8hz;
   assign tick_4hz     = r_tick_4hz;
   assign tick_2hz     = r_tick_2hz;
   assign boost_active = r_boost_active;
   assign boost_remain = r_remain;

endmodule : game_tick_sched

// File: tb/tb_game_tick_sched.sv
// ----------------------------------------------------------------------------
// tb_game_tick_sched
// Self-checking bench for game_tick_sched with BASE_DIV=4, BOOST_TICKS=3.
// The reference model counts enabled edges since reset and derives the
// base-tick index arithmetically; the boost window is a plain integer.
// ----------------------------------------------------------------------------
module tb_game_tick_sched;

   localparam int unsigned BD = 4;
   localparam int unsigned BT = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       reward_faster = 1'b0;
   logic       reward_test = 1'b0;
   logic       tick_8hz;
   logic       tick_4hz;
   logic       tick_2hz;
   logic       boost_active;
   logic [7:0] boost_remain;

   game_tick_sched #(
      .BASE_DIV      (BD),
      .BOOST_TICKS   (BT)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .en            (en),
      .reward_faster (reward_faster),
      .reward_test   (reward_test),
      .tick_8hz      (tick_8hz),
      .tick_4hz      (tick_4hz),
      .tick_2hz      (tick_2hz),
      .boost_active  (boost_active),
      .boost_remain  (boost_remain)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state
   int m_ecnt;
   int m_remain;
   bit m_active;
   bit m_t8;
   bit m_t4;
   bit m_t2;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      assert (got === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".tick_8hz"}, 8'(tick_8hz), 8'(m_t8));
      chk({tag, ".tick_4hz"}, 8'(tick_4hz), 8'(m_t4));
      chk({tag, ".tick_2hz"}, 8'(tick_2hz), 8'(m_t2));
      chk({tag, ".boost_active"}, 8'(boost_active), 8'(m_active));
      chk({tag, ".boost_remain"}, boost_remain, 8'(m_remain));
   endtask

   task automatic model_reset();
      m_ecnt   = 0;
      m_remain = 0;
      m_active = 1'b0;
      m_t8     = 1'b0;
      m_t4     = 1'b0;
      m_t2     = 1'b0;
   endtask

   // One clock edge of the behavioural model.
   task automatic model_edge(input bit e, input bit rf, input bit rt);
      int k;
      bit base;
      base = 1'b0;
      if (e) begin
         m_ecnt++;
         base = ((m_ecnt % BD) == 0);
      end
      if (base) begin
         k    = m_ecnt / BD;          // k-th base tick since reset, 1-based
         m_t8 = 1'b1;
         m_t2 = ((k % 4) == 0);
         m_t4 = m_active || ((k % 2) == 0);
      end else begin
         m_t8 = 1'b0;
         m_t4 = 1'b0;
         m_t2 = 1'b0;
      end
      if (rf) begin
         m_remain = BT;
      end else if (base && m_remain > 0) begin
         m_remain--;
      end
      m_active = (m_remain > 0) || rt;
   endtask

   // Drive inputs at the falling edge, clock once, check at the next fall.
   task automatic step(input bit e, input bit rf, input bit rt, input string tag);
      en            = e;
      reward_faster = rf;
      reward_test   = rt;
      @(posedge clk);
      model_edge(e, rf, rt);
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      en            = 1'b0;
      reward_faster = 1'b0;
      reward_test   = 1'b0;
      @(negedge clk);
      @(negedge clk);
      model_reset();
      check_all("reset");
      rst_n = 1'b1;
   endtask

   initial begin
      // free run
      do_reset();
      for (int e = 1; e <= 36; e++) step(1'b1, 1'b0, 1'b0, "free");

      // reward pulse on edge 1, window runs out at edge 12
      do_reset();
      step(1'b1, 1'b1, 1'b0, "boost_pulse");
      chk("boost_pulse_remain", boost_remain, 8'd3);
      for (int e = 2; e <= 20; e++) step(1'b1, 1'b0, 1'b0, "boost_run");

      // pause on edges 5..14, reward at 2 and at 10 (while paused)
      do_reset();
      for (int e = 1; e <= 26; e++)
         step(!(e >= 5 && e <= 14), (e == 2 || e == 10), 1'b0, "pause");

      // reload on the same edge as the decrement from 1
      do_reset();
      step(1'b1, 1'b1, 1'b0, "reload");
      for (int e = 2; e <= 11; e++) step(1'b1, 1'b0, 1'b0, "reload_pre");
      chk("reload_remain_before", boost_remain, 8'd1);
      step(1'b1, 1'b1, 1'b0, "reload_edge");
      chk("reload_wins_remain", boost_remain, 8'd3);
      chk("reload_wins_active", 8'(boost_active), 8'd1);
      for (int e = 13; e <= 28; e++) step(1'b1, 1'b0, 1'b0, "reload_post");

      // reward_test level
      do_reset();
      for (int e = 1; e <= 12; e++) step(1'b1, 1'b0, 1'b1, "test_on");
      for (int e = 13; e <= 20; e++) step(1'b1, 1'b0, 1'b0, "test_off");

      // asynchronous reset mid-boost
      do_reset();
      step(1'b1, 1'b1, 1'b0, "areset_pre");
      for (int e = 2; e <= 4; e++) step(1'b1, 1'b0, 1'b0, "areset_pre");
      #2;
      rst_n = 1'b0;
      #1;
      chk("areset.tick_8hz", 8'(tick_8hz), 8'd0);
      chk("areset.tick_4hz", 8'(tick_4hz), 8'd0);
      chk("areset.tick_2hz", 8'(tick_2hz), 8'd0);
      chk("areset.boost_active", 8'(boost_active), 8'd0);
      chk("areset.boost_remain", boost_remain, 8'd0);
      @(negedge clk);
      model_reset();
      rst_n = 1'b1;
      for (int e = 1; e <= 8; e++) step(1'b1, 1'b0, 1'b0, "areset_post");

      // randomized run against the model
      do_reset();
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 9) != 0),
              ($urandom_range(0, 24) == 0),
              ($urandom_range(0, 39) == 0),
              "random");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_game_tick_sched
